// File: rtl/led_blink_scheduler_if.sv
// Request bundle for led_blink_scheduler: two requesters, each with
// per-LED step patterns and a repeat count, plus the ready/valid handshake.
interface led_blink_scheduler_if #(
    parameter int PAT_W = 8,
    parameter int REP_W = 4
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [PAT_W-1:0] req0_pat1;
    logic [PAT_W-1:0] req0_pat2;
    logic [REP_W-1:0] req0_rep;
    logic [PAT_W-1:0] req1_pat1;
    logic [PAT_W-1:0] req1_pat2;
    logic [REP_W-1:0] req1_rep;

    modport master (
        output req_valid, req0_pat1, req0_pat2, req0_rep,
               req1_pat1, req1_pat2, req1_rep,
        input  req_ready
    );

    modport slave (
        input  req_valid, req0_pat1, req0_pat2, req0_rep,
               req1_pat1, req1_pat2, req1_rep,
        output req_ready
    );
endinterface

// File: rtl/led_blink_scheduler.sv
// Fixed-priority scheduler of LED blink jobs with an idle heartbeat.
// Optional `define LED_PREEMPT_EN lets requester 0 abort a running requester-1 job.
module led_blink_scheduler #(
    parameter int TICK_DIV = 4800000,
    parameter int HB_DIV   = 48000000,
    parameter int PAT_W    = 8,
    parameter int REP_W    = 4
) (
    input  logic                  clk_48MHz,
    input  logic                  rst_n,
    led_blink_scheduler_if.slave  req,
    output logic                  oLED1,
    output logic                  oLED2,
    output logic                  busy,
    output logic                  grant_id,
    output logic                  done
);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int HB_W   = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
    localparam int STEP_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HB_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PAT_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state;
    logic [TICK_W-1:0] tick;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] step_nxt;
    logic [REP_W-1:0]  rep_left;
    logic [PAT_W-1:0]  pat1_q;
    logic [PAT_W-1:0]  pat2_q;
    logic [HB_W-1:0]   hb_cnt;
    logic              hb;
    logic              hb_next;

    logic              accept;
    logic              sel1;
    logic [PAT_W-1:0]  pat1_in;
    logic [PAT_W-1:0]  pat2_in;
    logic [REP_W-1:0]  rep_in;

    always_comb begin
        req.req_ready = '0;
        if (state == S_IDLE) begin
            req.req_ready[0] = req.req_valid[0];
            req.req_ready[1] = req.req_valid[1] & ~req.req_valid[0];
        end
`ifdef LED_PREEMPT_EN
        else if (state == S_RUN && grant_id) begin
            req.req_ready[0] = req.req_valid[0];
        end
`endif
    end

    always_comb begin
        accept   = |(req.req_valid & req.req_ready);
        sel1     = ~req.req_ready[0];
        pat1_in  = sel1 ? req.req1_pat1 : req.req0_pat1;
        pat2_in  = sel1 ? req.req1_pat2 : req.req0_pat2;
        rep_in   = sel1 ? req.req1_rep  : req.req0_rep;
        step_nxt = step + STEP_W'(1);
        // LEDs register the post-edge heartbeat so that oLED tracks hb with no lag in IDLE.
        hb_next  = (hb_cnt == HB_LAST) ? ~hb : hb;
    end

    always_ff @(posedge clk_48MHz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tick     <= '0;
            step     <= '0;
            rep_left <= '0;
            pat1_q   <= '0;
            pat2_q   <= '0;
            hb_cnt   <= '0;
            hb       <= 1'b0;
            oLED1    <= 1'b0;
            oLED2    <= 1'b0;
            busy     <= 1'b0;
            grant_id <= 1'b0;
            done     <= 1'b0;
        end else begin
            hb_cnt <= (hb_cnt == HB_LAST) ? '0 : hb_cnt + HB_W'(1);
            hb     <= hb_next;

            // Acceptance is only possible in IDLE, or in RUN when preemption is built in.
            if (accept) begin
                pat1_q   <= pat1_in;
                pat2_q   <= pat2_in;
                rep_left <= rep_in;
                grant_id <= sel1;
                step     <= '0;
                tick     <= '0;
                state    <= S_RUN;
                busy     <= 1'b1;
                done     <= 1'b0;
                oLED1    <= pat1_in[0];
                oLED2    <= pat2_in[0];
            end else begin
                case (state)
                    S_IDLE: begin
                        oLED1 <= hb_next;
                        oLED2 <= hb_next;
                        done  <= 1'b0;
                    end
                    S_RUN: begin
                        if (tick == TICK_LAST) begin
                            tick <= '0;
                            if (step == STEP_LAST) begin
                                if (rep_left != '0) begin
                                    rep_left <= rep_left - REP_W'(1);
                                    step     <= '0;
                                    oLED1    <= pat1_q[0];
                                    oLED2    <= pat2_q[0];
                                end else begin
                                    state <= S_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                            end else begin
                                step  <= step_nxt;
                                oLED1 <= pat1_q[step_nxt];
                                oLED2 <= pat2_q[step_nxt];
                            end
                        end else begin
                            tick <= tick + TICK_W'(1);
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        done  <= 1'b0;
                        oLED1 <= hb_next;
                        oLED2 <= hb_next;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_led_blink_scheduler.sv
// Directed bench for led_blink_scheduler (TICK_DIV=4, HB_DIV=8, PAT_W=8, REP_W=4).
// Build with +define+LED_PREEMPT_EN to exercise the preemption path.
module tb_led_blink_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    logic oLED1, oLED2, busy, grant_id, done;
    int   checks = 0;
    int   failures = 0;
    int   n_edges;

    led_blink_scheduler_if #(.PAT_W(8), .REP_W(4)) bus ();

    led_blink_scheduler #(
        .TICK_DIV(4),
        .HB_DIV  (8),
        .PAT_W   (8),
        .REP_W   (4)
    ) dut (
        .clk_48MHz(clk),
        .rst_n    (rst_n),
        .req      (bus),
        .oLED1    (oLED1),
        .oLED2    (oLED2),
        .busy     (busy),
        .grant_id (grant_id),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Clock edges seen since reset release; the heartbeat level follows from it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n_edges <= 0;
        else        n_edges <= n_edges + 1;
    end

    function automatic logic hb_exp();
        return ((n_edges / 8) % 2) == 1;
    endfunction

    typedef struct {
        logic       id;
        logic [7:0] p1;
        logic [7:0] p2;
        logic [3:0] rep;
    } job_t;

    job_t jobs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input logic id, input logic [7:0] p1, input logic [7:0] p2,
                           input logic [3:0] rep);
        if (id == 1'b0) begin
            bus.req0_pat1 = p1; bus.req0_pat2 = p2; bus.req0_rep = rep;
            bus.req_valid[0] = 1'b1;
        end else begin
            bus.req1_pat1 = p1; bus.req1_pat2 = p2; bus.req1_rep = rep;
            bus.req_valid[1] = 1'b1;
        end
    endtask

    task automatic check_cycle(input logic id, input logic [7:0] p1, input logic [7:0] p2,
                               input int c);
        int s;
        s = ((c - 1) / 4) % 8;
        chk("led1_run", 32'(oLED1), 32'(p1[s]));
        chk("led2_run", 32'(oLED2), 32'(p2[s]));
        chk("busy_run", 32'(busy), 32'd1);
        chk("grant_run", 32'(grant_id), 32'(id));
        chk("done_run", 32'(done), 32'd0);
    endtask

    // Checks cycles start..end of a job counted from its accept edge, then the DONE cycle.
    task automatic play(input logic id, input logic [7:0] p1, input logic [7:0] p2,
                        input logic [3:0] rep, input int start);
        int total;
        total = (int'(rep) + 1) * 32;
        for (int c = start; c <= total; c++) begin
            @(negedge clk);
            check_cycle(id, p1, p2, c);
            chk("ready_run", 32'(bus.req_ready), 32'd0);
            if (c == start) bus.req_valid[id] = 1'b0;
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("led1_done_hold", 32'(oLED1), 32'(p1[7]));
        chk("led2_done_hold", 32'(oLED2), 32'(p2[7]));
        chk("grant_done", 32'(grant_id), 32'(id));
    endtask

    task automatic idle_check(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            chk("led1_hb", 32'(oLED1), 32'(hb_exp()));
            chk("led2_hb", 32'(oLED2), 32'(hb_exp()));
            chk("busy_idle", 32'(busy), 32'd0);
            chk("done_idle", 32'(done), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        jobs[0] = '{id: 1'b1, p1: 8'hA5, p2: 8'h0F, rep: 4'd0};
        jobs[1] = '{id: 1'b0, p1: 8'h01, p2: 8'h80, rep: 4'd2};
        jobs[2] = '{id: 1'b0, p1: 8'h3C, p2: 8'hC3, rep: 4'd1};
        jobs[3] = '{id: 1'b1, p1: 8'hFF, p2: 8'h00, rep: 4'd0};

        rst_n = 1'b0;
        bus.req_valid = 2'b00;
        bus.req0_pat1 = '0; bus.req0_pat2 = '0; bus.req0_rep = '0;
        bus.req1_pat1 = '0; bus.req1_pat2 = '0; bus.req1_rep = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_led1", 32'(oLED1), 32'd0);
        chk("rst_led2", 32'(oLED2), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // Heartbeat only: 0 for 8 cycles then toggling every 8
        idle_check(20);

        // Table of single-requester jobs, each issued in the first IDLE cycle after the last
        foreach (jobs[i]) begin
            set_req(jobs[i].id, jobs[i].p1, jobs[i].p2, jobs[i].rep);
            #1;
            chk("ready_single", 32'(bus.req_ready), jobs[i].id ? 32'd2 : 32'd1);
            play(jobs[i].id, jobs[i].p1, jobs[i].p2, jobs[i].rep, 1);
            idle_check(1);
        end

        // Both requesters at once: req0 wins, req1 follows right after req0's done
        set_req(1'b1, 8'h96, 8'h69, 4'd0);
        set_req(1'b0, 8'h5A, 8'hA5, 4'd0);
        #1;
        chk("ready_both", 32'(bus.req_ready), 32'd1);
        play(1'b0, 8'h5A, 8'hA5, 4'd0, 1);
        @(negedge clk);
        chk("ready_req1_after", 32'(bus.req_ready), 32'd2);
        chk("done_after_both", 32'(done), 32'd0);
        play(1'b1, 8'h96, 8'h69, 4'd0, 1);
        idle_check(1);

        // Reset in the middle of step 3
        set_req(1'b1, 8'hFF, 8'h08, 4'd3);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            check_cycle(1'b1, 8'hFF, 8'h08, c);
            if (c == 1) bus.req_valid[1] = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_led1", 32'(oLED1), 32'd0);
        chk("midrst_led2", 32'(oLED2), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_grant", 32'(grant_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check(10);

        // req0 arrives at step 2 of a running req1 job
        set_req(1'b1, 8'hF0, 8'h3C, 4'd0);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check_cycle(1'b1, 8'hF0, 8'h3C, c);
            if (c == 1) bus.req_valid[1] = 1'b0;
        end
        set_req(1'b0, 8'h0B, 8'hC2, 4'd0);
        #1;
`ifdef LED_PREEMPT_EN
        chk("ready_preempt", 32'(bus.req_ready), 32'd1);
        play(1'b0, 8'h0B, 8'hC2, 4'd0, 1);
`else
        chk("ready_no_preempt", 32'(bus.req_ready), 32'd0);
        play(1'b1, 8'hF0, 8'h3C, 4'd0, 10);
        @(negedge clk);
        chk("ready_req0_after", 32'(bus.req_ready), 32'd1);
        play(1'b0, 8'h0B, 8'hC2, 4'd0, 1);
`endif
        idle_check(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
